lsu_exec: RTL and testbench

- Single-issue load/store execute stage, directly downstream of the LSU issue queue. Consumes one issued uop per handshake.
- Stores: computes address and writes the pre-allocated store-buffer entry (addr/data/mask). Commit-time drain belongs to the store buffer.
- Loads: compute address, query store buffer for forwarding, else issue a D-cache read. Result is aligned and sign/zero-extended, then broadcast on a CDB port.
- Backpressure: fu_ready_o gates the issue select.

---
 rtl/decode_pkg.sv | 11 +
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_align.sv | 25 ++
 rtl/lsu_exec.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_exec.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Decoded micro-op format shared by the issue queues and execute stages.
package decode_pkg;

  typedef struct packed {
    logic [11:0] imm;
    logic        is_store;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } uop_t;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, access-size encodings and
// byte-mask / load-extension helpers used by lsu_align and the store buffer.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = XLEN / 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SBWR  = 3'd1,
    ST_FWD   = 3'd2,
    ST_DREQ  = 3'd3,
    ST_DWAIT = 3'd4,
    ST_WB    = 3'd5
  } lsu_state_e;

  // Lanes pushed past byte 3 are dropped rather than wrapped.
  function automatic logic [NBYTES-1:0] size_mask(input logic [1:0] size,
                                                  input logic [1:0] off);
    logic [NBYTES-1:0]   base;
    logic [2*NBYTES-1:0] wide;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    wide = {{NBYTES{1'b0}}, base} << off;
    return wide[NBYTES-1:0];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0] size,
                                                  input logic is_unsigned);
    case (size)
      SZ_B:    return is_unsigned ? {24'h000000, word[7:0]}
                                  : {{24{word[7]}}, word[7:0]};
      SZ_H:    return is_unsigned ? {16'h0000, word[15:0]}
                                  : {{16{word[15]}}, word[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, store data lane shift and load
// extract/extend. Shared with the store buffer.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [1:0]          ea_lo,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W-1:0]   ld_word,
  output logic [DATA_W/8-1:0] mask,
  output logic [DATA_W-1:0]   st_lane,
  output logic [DATA_W-1:0]   ld_result
);

  logic [4:0] sh_s;

  assign sh_s      = {ea_lo, 3'b000};
  assign mask      = size_mask(size, ea_lo);
  assign st_lane   = st_data << sh_s;
  assign ld_result = load_extend(ld_word >> sh_s, size, is_unsigned);

endmodule

// File: rtl/lsu_exec.sv
// Load/store execute stage: address generation, store-buffer write,
// forwarding query, D-cache read and CDB writeback.
// Optional build macro: LSU_MISALIGN_EXC_EN (misaligned accesses trap).
module lsu_exec
  import decode_pkg::*;
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int SB_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                lsu_en_i,
  input  uop_t                lsu_uop_i,
  input  logic [DATA_W-1:0]   lsu_v1_i,
  input  logic [DATA_W-1:0]   lsu_v2_i,
  input  logic [TAG_W-1:0]    lsu_dst_i,
  input  logic [SB_W-1:0]     lsu_sb_id_i,
  output logic                fu_ready_o,
  output logic                sb_wr_en_o,
  output logic [SB_W-1:0]     sb_wr_id_o,
  output logic [DATA_W-1:0]   sb_wr_addr_o,
  output logic [DATA_W-1:0]   sb_wr_data_o,
  output logic [DATA_W/8-1:0] sb_wr_mask_o,
  output logic [DATA_W-1:0]   sb_fwd_addr_o,
  output logic [DATA_W/8-1:0] sb_fwd_mask_o,
  output logic [SB_W-1:0]     sb_fwd_id_o,
  input  logic                sb_fwd_hit_i,
  input  logic [DATA_W-1:0]   sb_fwd_data_i,
  input  logic                sb_fwd_stall_i,
  output logic                dc_req_valid_o,
  input  logic                dc_req_ready_i,
  output logic [DATA_W-1:0]   dc_req_addr_o,
  input  logic                dc_rsp_valid_i,
  input  logic [DATA_W-1:0]   dc_rsp_data_i,
  output logic                cdb_valid_o,
  input  logic                cdb_ready_i,
  output logic [TAG_W-1:0]    cdb_tag_o,
  output logic [DATA_W-1:0]   cdb_val_o,
  output logic                cdb_exc_o
);

  lsu_state_e          state_r, state_next_s;
  logic                fu_ready_r, sb_wr_en_r, dc_req_valid_r, cdb_valid_r, cdb_exc_r;
  logic                orphan_r, orphan_next_s;
  logic [TAG_W-1:0]    tag_r;
  logic [DATA_W-1:0]   ea_r, st_data_r, cdb_val_r;
  logic [1:0]          size_r;
  logic                uns_r;
  logic [SB_W-1:0]     sb_id_r;
  logic [DATA_W/8-1:0] mask_r;

  logic [DATA_W-1:0]   ea_s, ld_word_s, st_lane_s, ld_result_s;
  logic [DATA_W/8-1:0] mask_s;
  logic [1:0]          al_off_s, al_size_s;
  logic                accept_s, mis_s, load_done_s;

  assign ea_s     = lsu_v1_i + {{(DATA_W-12){lsu_uop_i.imm[11]}}, lsu_uop_i.imm};
  assign accept_s = lsu_en_i && fu_ready_r && !flush_i;

`ifdef LSU_MISALIGN_EXC_EN
  assign mis_s = misaligned(lsu_uop_i.mem_size, ea_s[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  // The aligner serves the incoming uop while idle, the latched load afterwards.
  assign al_off_s  = (state_r == ST_IDLE) ? ea_s[1:0] : ea_r[1:0];
  assign al_size_s = (state_r == ST_IDLE) ? lsu_uop_i.mem_size : size_r;
  assign ld_word_s = (state_r == ST_FWD) ? sb_fwd_data_i : dc_rsp_data_i;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .ea_lo       (al_off_s),
    .size        (al_size_s),
    .is_unsigned (uns_r),
    .st_data     (lsu_v2_i),
    .ld_word     (ld_word_s),
    .mask        (mask_s),
    .st_lane     (st_lane_s),
    .ld_result   (ld_result_s)
  );

  assign load_done_s = !flush_i &&
                       ((state_r == ST_FWD && !sb_fwd_stall_i && sb_fwd_hit_i) ||
                        (state_r == ST_DWAIT && dc_rsp_valid_i && !orphan_r));

  // Next-state logic; flush wins over every transition.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (mis_s)                   state_next_s = ST_WB;
            else if (lsu_uop_i.is_store) state_next_s = ST_SBWR;
            else                         state_next_s = ST_FWD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SBWR: state_next_s = ST_WB;
        ST_FWD: begin
          if (sb_fwd_stall_i)    state_next_s = ST_FWD;
          else if (sb_fwd_hit_i) state_next_s = ST_WB;
          else                   state_next_s = ST_DREQ;
        end
        ST_DREQ: begin
          if (dc_req_valid_r && dc_req_ready_i) state_next_s = ST_DWAIT;
          else                                  state_next_s = ST_DREQ;
        end
        ST_DWAIT: begin
          if (dc_rsp_valid_i && !orphan_r) state_next_s = ST_DWAIT == ST_DWAIT ? ST_WB : ST_WB;
          else                             state_next_s = ST_DWAIT;
        end
        ST_WB: begin
          if (cdb_ready_i) state_next_s = ST_IDLE;
          else             state_next_s = ST_WB;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // A cache read that was handed off but flushed leaves one response to discard.
  always_comb begin
    orphan_next_s = orphan_r;
    if (orphan_r && dc_rsp_valid_i) begin
      orphan_next_s = 1'b0;
    end else if (flush_i && ((state_r == ST_DWAIT && !dc_rsp_valid_i) ||
                             (state_r == ST_DREQ && dc_req_valid_r && dc_req_ready_i))) begin
      orphan_next_s = 1'b1;
    end else begin
      orphan_next_s = orphan_r;
    end
  end

  // State, registered handshake outputs and latched operation fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      orphan_r       <= 1'b0;
      fu_ready_r     <= 1'b1;
      sb_wr_en_r     <= 1'b0;
      dc_req_valid_r <= 1'b0;
      cdb_valid_r    <= 1'b0;
      cdb_exc_r      <= 1'b0;
      cdb_val_r      <= {DATA_W{1'b0}};
      tag_r          <= {TAG_W{1'b0}};
      ea_r           <= {DATA_W{1'b0}};
      st_data_r      <= {DATA_W{1'b0}};
      size_r         <= 2'b00;
      uns_r          <= 1'b0;
      sb_id_r        <= {SB_W{1'b0}};
      mask_r         <= {(DATA_W/8){1'b0}};
    end else begin
      state_r        <= state_next_s;
      orphan_r       <= orphan_next_s;
      fu_ready_r     <= (state_next_s == ST_IDLE);
      sb_wr_en_r     <= (state_next_s == ST_SBWR);
      dc_req_valid_r <= (state_next_s == ST_DREQ) && !orphan_next_s;
      cdb_valid_r    <= (state_next_s == ST_WB);
      if (accept_s) begin
        tag_r     <= lsu_dst_i;
        ea_r      <= ea_s;
        size_r    <= lsu_uop_i.mem_size;
        uns_r     <= lsu_uop_i.mem_unsigned;
        sb_id_r   <= lsu_sb_id_i;
        st_data_r <= st_lane_s;
        mask_r    <= mask_s;
        cdb_val_r <= mis_s ? ea_s : {DATA_W{1'b0}};
        cdb_exc_r <= mis_s;
      end else if (load_done_s) begin
        cdb_val_r <= ld_result_s;
        cdb_exc_r <= 1'b0;
      end
    end
  end

  assign fu_ready_o     = fu_ready_r;
  assign sb_wr_en_o     = sb_wr_en_r;
  assign sb_wr_id_o     = sb_id_r;
  assign sb_wr_addr_o   = {ea_r[DATA_W-1:2], 2'b00};
  assign sb_wr_data_o   = st_data_r;
  assign sb_wr_mask_o   = mask_r;
  assign sb_fwd_addr_o  = {ea_r[DATA_W-1:2], 2'b00};
  assign sb_fwd_mask_o  = mask_r;
  assign sb_fwd_id_o    = sb_id_r;
  assign dc_req_valid_o = dc_req_valid_r;
  assign dc_req_addr_o  = {ea_r[DATA_W-1:2], 2'b00};
  assign cdb_valid_o    = cdb_valid_r;
  assign cdb_tag_o      = tag_r;
  assign cdb_val_o      = cdb_val_r;
`ifdef LSU_MISALIGN_EXC_EN
  assign cdb_exc_o      = cdb_exc_r;
`else
  assign cdb_exc_o      = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_exec.sv
// Directed self-checking bench for lsu_exec: stores, loads (cache and
// forwarded), stalls, backpressure, flushes and misaligned accesses.
module tb_lsu_exec;
  import decode_pkg::*;

  logic        clk, rst, flush_i, lsu_en_i;
  uop_t        uop;
  logic [31:0] lsu_v1_i, lsu_v2_i;
  logic [5:0]  lsu_dst_i;
  logic [3:0]  lsu_sb_id_i;
  logic        fu_ready_o, sb_wr_en_o;
  logic [3:0]  sb_wr_id_o, sb_wr_mask_o, sb_fwd_mask_o, sb_fwd_id_o;
  logic [31:0] sb_wr_addr_o, sb_wr_data_o, sb_fwd_addr_o;
  logic        sb_fwd_hit_i, sb_fwd_stall_i;
  logic [31:0] sb_fwd_data_i;
  logic        dc_req_valid_o, dc_req_ready_i, dc_rsp_valid_i;
  logic [31:0] dc_req_addr_o, dc_rsp_data_i;
  logic        cdb_valid_o, cdb_ready_i, cdb_exc_o;
  logic [5:0]  cdb_tag_o;
  logic [31:0] cdb_val_o;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_exec dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .lsu_en_i(lsu_en_i),
    .lsu_uop_i(uop), .lsu_v1_i(lsu_v1_i), .lsu_v2_i(lsu_v2_i),
    .lsu_dst_i(lsu_dst_i), .lsu_sb_id_i(lsu_sb_id_i), .fu_ready_o(fu_ready_o),
    .sb_wr_en_o(sb_wr_en_o), .sb_wr_id_o(sb_wr_id_o), .sb_wr_addr_o(sb_wr_addr_o),
    .sb_wr_data_o(sb_wr_data_o), .sb_wr_mask_o(sb_wr_mask_o),
    .sb_fwd_addr_o(sb_fwd_addr_o), .sb_fwd_mask_o(sb_fwd_mask_o),
    .sb_fwd_id_o(sb_fwd_id_o), .sb_fwd_hit_i(sb_fwd_hit_i),
    .sb_fwd_data_i(sb_fwd_data_i), .sb_fwd_stall_i(sb_fwd_stall_i),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
    .dc_req_addr_o(dc_req_addr_o), .dc_rsp_valid_i(dc_rsp_valid_i),
    .dc_rsp_data_i(dc_rsp_data_i), .cdb_valid_o(cdb_valid_o),
    .cdb_ready_i(cdb_ready_i), .cdb_tag_o(cdb_tag_o), .cdb_val_o(cdb_val_o),
    .cdb_exc_o(cdb_exc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] v1, input logic [11:0] imm, input logic st,
                       input logic [1:0] sz, input logic uns, input logic [31:0] v2,
                       input logic [5:0] tag, input logic [3:0] id);
    uop.imm          = imm;
    uop.is_store     = st;
    uop.mem_size     = sz;
    uop.mem_unsigned = uns;
    lsu_v1_i    = v1;
    lsu_v2_i    = v2;
    lsu_dst_i   = tag;
    lsu_sb_id_i = id;
    lsu_en_i    = 1'b1;
    tick();
    lsu_en_i    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; lsu_en_i = 1'b0; uop = '0;
    lsu_v1_i = 32'h0; lsu_v2_i = 32'h0; lsu_dst_i = 6'd0; lsu_sb_id_i = 4'd0;
    sb_fwd_hit_i = 1'b0; sb_fwd_stall_i = 1'b0; sb_fwd_data_i = 32'h0;
    dc_req_ready_i = 1'b1; dc_rsp_valid_i = 1'b0; dc_rsp_data_i = 32'h0;
    cdb_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_fu_ready", {31'd0, fu_ready_o}, 32'd1);
    chk("rst_cdb_valid", {31'd0, cdb_valid_o}, 32'd0);
    chk("rst_dc_valid", {31'd0, dc_req_valid_o}, 32'd0);
    chk("rst_sb_wr_en", {31'd0, sb_wr_en_o}, 32'd0);
    chk("rst_cdb_val", cdb_val_o, 32'd0);

    // sw 0x1004
    issue(32'h1000, 12'h004, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 6'd5, 4'd3);
    chk("sw_wr_en", {31'd0, sb_wr_en_o}, 32'd1);
    chk("sw_wr_id", {28'd0, sb_wr_id_o}, 32'd3);
    chk("sw_wr_addr", sb_wr_addr_o, 32'h1004);
    chk("sw_wr_data", sb_wr_data_o, 32'hDEADBEEF);
    chk("sw_wr_mask", {28'd0, sb_wr_mask_o}, 32'hF);
    chk("sw_cdb_early", {31'd0, cdb_valid_o}, 32'd0);
    chk("sw_fu_busy", {31'd0, fu_ready_o}, 32'd0);
    tick();
    chk("sw_wr_pulse_end", {31'd0, sb_wr_en_o}, 32'd0);
    chk("sw_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("sw_cdb_tag", {26'd0, cdb_tag_o}, 32'd5);
    chk("sw_cdb_val", cdb_val_o, 32'd0);
    chk("sw_cdb_exc", {31'd0, cdb_exc_o}, 32'd0);
    tick();
    chk("sw_done_valid", {31'd0, cdb_valid_o}, 32'd0);
    chk("sw_done_ready", {31'd0, fu_ready_o}, 32'd1);

    // sb at 0x1002: byte lane 2
    issue(32'h1000, 12'h002, 1'b1, 2'd0, 1'b0, 32'h000000AB, 6'd6, 4'd4);
    chk("sb_wr_data", sb_wr_data_o, 32'h00AB0000);
    chk("sb_wr_mask", {28'd0, sb_wr_mask_o}, 32'h4);
    chk("sb_wr_addr", sb_wr_addr_o, 32'h1000);
    tick(); tick();

    // lb 0x2003 through the cache
    issue(32'h2000, 12'h003, 1'b0, 2'd0, 1'b0, 32'h0, 6'd7, 4'd2);
    chk("lb_fwd_addr", sb_fwd_addr_o, 32'h2000);
    chk("lb_fwd_mask", {28'd0, sb_fwd_mask_o}, 32'h8);
    chk("lb_fwd_id", {28'd0, sb_fwd_id_o}, 32'd2);
    chk("lb_no_req_yet", {31'd0, dc_req_valid_o}, 32'd0);
    tick();
    chk("lb_req_valid", {31'd0, dc_req_valid_o}, 32'd1);
    chk("lb_req_addr", dc_req_addr_o, 32'h2000);
    tick();
    chk("lb_req_drop", {31'd0, dc_req_valid_o}, 32'd0);
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'h80FFFF00;
    tick();
    dc_rsp_valid_i = 1'b0;
    chk("lb_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("lb_cdb_tag", {26'd0, cdb_tag_o}, 32'd7);
    chk("lb_cdb_val", cdb_val_o, 32'hFFFFFF80);
    tick();
    chk("lb_done", {31'd0, cdb_valid_o}, 32'd0);

    // lbu, same access
    issue(32'h2000, 12'h003, 1'b0, 2'd0, 1'b1, 32'h0, 6'd8, 4'd2);
    tick(); tick();
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'h80FFFF00;
    tick();
    dc_rsp_valid_i = 1'b0;
    chk("lbu_cdb_val", cdb_val_o, 32'h00000080);
    tick();

    // lh 0x3002 forwarded
    issue(32'h3000, 12'h002, 1'b0, 2'd1, 1'b0, 32'h0, 6'd9, 4'd5);
    sb_fwd_hit_i = 1'b1; sb_fwd_data_i = 32'h12345678;
    chk("lhf_fwd_mask", {28'd0, sb_fwd_mask_o}, 32'hC);
    tick();
    sb_fwd_hit_i = 1'b0;
    chk("lhf_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("lhf_cdb_val", cdb_val_o, 32'h00001234);
    chk("lhf_no_dc_req", {31'd0, dc_req_valid_o}, 32'd0);
    tick();

    // lh 0x3002: three stall cycles, then hit
    sb_fwd_stall_i = 1'b1;
    issue(32'h3000, 12'h002, 1'b0, 2'd1, 1'b0, 32'h0, 6'd10, 4'd5);
    for (int i = 0; i < 3; i++) begin
      chk("stall_fwd_addr", sb_fwd_addr_o, 32'h3000);
      chk("stall_no_cdb", {31'd0, cdb_valid_o}, 32'd0);
      chk("stall_no_dc", {31'd0, dc_req_valid_o}, 32'd0);
      chk("stall_fu_busy", {31'd0, fu_ready_o}, 32'd0);
      tick();
    end
    sb_fwd_stall_i = 1'b0; sb_fwd_hit_i = 1'b1; sb_fwd_data_i = 32'hABCD0000;
    tick();
    sb_fwd_hit_i = 1'b0;
    chk("stall_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("stall_cdb_val", cdb_val_o, 32'hFFFFABCD);
    tick();

    // lw 0x4000 (negative imm) with request and result backpressure
    dc_req_ready_i = 1'b0;
    issue(32'h4008, 12'hFF8, 1'b0, 2'd2, 1'b0, 32'h0, 6'd11, 4'd6);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", {31'd0, dc_req_valid_o}, 32'd1);
      chk("bp_req_addr", dc_req_addr_o, 32'h4000);
      chk("bp_fu_busy", {31'd0, fu_ready_o}, 32'd0);
      tick();
    end
    dc_req_ready_i = 1'b1;
    chk("bp_req_still", {31'd0, dc_req_valid_o}, 32'd1);
    tick();
    cdb_ready_i = 1'b0;
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'h11223344;
    tick();
    dc_rsp_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
      chk("bp_cdb_val", cdb_val_o, 32'h11223344);
      chk("bp_cdb_fu", {31'd0, fu_ready_o}, 32'd0);
      tick();
    end
    cdb_ready_i = 1'b1;
    chk("bp_cdb_hold", {31'd0, cdb_valid_o}, 32'd1);
    tick();
    chk("bp_done_valid", {31'd0, cdb_valid_o}, 32'd0);
    chk("bp_done_ready", {31'd0, fu_ready_o}, 32'd1);

    // lw at 0x1001
`ifdef LSU_MISALIGN_EXC_EN
    issue(32'h1001, 12'h000, 1'b0, 2'd2, 1'b0, 32'h0, 6'd12, 4'd7);
    chk("mis_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("mis_cdb_exc", {31'd0, cdb_exc_o}, 32'd1);
    chk("mis_cdb_val", cdb_val_o, 32'h1001);
    chk("mis_no_dc", {31'd0, dc_req_valid_o}, 32'd0);
    chk("mis_no_sb", {31'd0, sb_wr_en_o}, 32'd0);
    tick();
    issue(32'h1003, 12'h000, 1'b1, 2'd1, 1'b0, 32'h00001234, 6'd13, 4'd7);
    chk("mis_st_no_sb", {31'd0, sb_wr_en_o}, 32'd0);
    chk("mis_st_exc", {31'd0, cdb_exc_o}, 32'd1);
    chk("mis_st_val", cdb_val_o, 32'h1003);
    tick();
`else
    issue(32'h1001, 12'h000, 1'b0, 2'd2, 1'b0, 32'h0, 6'd12, 4'd7);
    chk("mis_fwd_mask", {28'd0, sb_fwd_mask_o}, 32'hE);
    tick();
    chk("mis_req_addr", dc_req_addr_o, 32'h1000);
    tick();
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'hA1B2C3D4;
    tick();
    dc_rsp_valid_i = 1'b0;
    chk("mis_cdb_val", cdb_val_o, 32'h00A1B2C3);
    chk("mis_cdb_exc", {31'd0, cdb_exc_o}, 32'd0);
    tick();
    issue(32'h1003, 12'h000, 1'b1, 2'd1, 1'b0, 32'h00001234, 6'd13, 4'd7);
    chk("mis_st_mask", {28'd0, sb_wr_mask_o}, 32'h8);
    chk("mis_st_data", sb_wr_data_o, 32'h34000000);
    tick(); tick();
`endif

    // flush during DWAIT, then a new load must wait for the orphan response
    issue(32'h5000, 12'h000, 1'b0, 2'd2, 1'b0, 32'h0, 6'd14, 4'd8);
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_cdb_valid", {31'd0, cdb_valid_o}, 32'd0);
    chk("fl_dc_valid", {31'd0, dc_req_valid_o}, 32'd0);
    chk("fl_fu_ready", {31'd0, fu_ready_o}, 32'd1);
    issue(32'h6004, 12'h000, 1'b0, 2'd2, 1'b0, 32'h0, 6'd15, 4'd9);
    tick();
    chk("orph_req_held1", {31'd0, dc_req_valid_o}, 32'd0);
    tick();
    chk("orph_req_held2", {31'd0, dc_req_valid_o}, 32'd0);
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'hBAD0BAD0;
    tick();
    dc_rsp_valid_i = 1'b0;
    chk("orph_req_valid", {31'd0, dc_req_valid_o}, 32'd1);
    chk("orph_req_addr", dc_req_addr_o, 32'h6004);
    chk("orph_no_cdb", {31'd0, cdb_valid_o}, 32'd0);
    tick();
    dc_rsp_valid_i = 1'b1; dc_rsp_data_i = 32'h0000CAFE;
    tick();
    dc_rsp_valid_i = 1'b0;
    chk("orph_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    chk("orph_cdb_tag", {26'd0, cdb_tag_o}, 32'd15);
    chk("orph_cdb_val", cdb_val_o, 32'h0000CAFE);
    tick();

    // issue coincident with flush is refused
    flush_i = 1'b1;
    issue(32'h7000, 12'h000, 1'b1, 2'd2, 1'b0, 32'h55AA55AA, 6'd16, 4'd1);
    flush_i = 1'b0;
    chk("flen_no_sb", {31'd0, sb_wr_en_o}, 32'd0);
    chk("flen_fu_ready", {31'd0, fu_ready_o}, 32'd1);
    tick();
    chk("flen_no_cdb", {31'd0, cdb_valid_o}, 32'd0);

    // flush while waiting for the CDB grant
    cdb_ready_i = 1'b0;
    issue(32'h7000, 12'h000, 1'b1, 2'd2, 1'b0, 32'h55AA55AA, 6'd17, 4'd1);
    tick();
    chk("flwb_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cdb_ready_i = 1'b1;
    chk("flwb_cdb_drop", {31'd0, cdb_valid_o}, 32'd0);
    chk("flwb_fu_ready", {31'd0, fu_ready_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
